// File: rtl/alu_arb_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU op codes and the
// response FSM state type.
package alu_arb_pkg;

    localparam int OP_W    = 3;
    localparam int STATE_W = 1;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;

    // IDLE: no result held. RESP: result register holds an undelivered result.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Round-robin picker: returns the first requester at or after ptr+1
// (modulo NREQ), as a one-hot grant plus its binary index.
module alu_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Walk the requesters starting just after the last winner; first hit wins.
    always_comb begin
        int            c;
        logic [IDW-1:0] c_idx;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        c_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            c     = (int'(ptr) + i) % NREQ;
            c_idx = IDW'(c);
            if (!any && req[c_idx]) begin
                grant[c_idx] = 1'b1;
                idx          = c_idx;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU (add/sub/and/or/xor, {carry,Y} result) between NREQ
// requesters with round-robin arbitration and a single registered response
// that holds under backpressure.
// Optional feature: define ALU_ARB_STATS_EN to add per-requester saturating
// accept counters on port op_cnt.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ*OP_W-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_y,
    output logic                 rsp_carry
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*8-1:0]    op_cnt
`endif
);

    // Operands are zero-extended by one bit so add carry and sub borrow
    // both land in bit W; unused op codes produce zero.
    function automatic logic [W:0] alu_f(input logic [OP_W-1:0] op,
                                         input logic [W-1:0]    a,
                                         input logic [W-1:0]    b);
        logic [W:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_y;
    logic            r_rsp_carry;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_can_accept;
    logic            w_accept;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [OP_W-1:0] w_sel_op;
    logic [W:0]      w_alu;

    alu_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // A new op can enter when the result slot is empty or is being drained
    // this cycle; nothing is granted while reset is asserted, so no op can be
    // accepted only to be discarded.
    assign w_can_accept = !rst && ((r_state == IDLE) || (rsp_ready && r_state == RESP));
    assign w_accept     = w_can_accept && w_any;
    assign req_ready    = w_can_accept ? w_grant : '0;

    assign w_sel_a  = req_a[w_idx*W +: W];
    assign w_sel_b  = req_b[w_idx*W +: W];
    assign w_sel_op = req_op[w_idx*OP_W +: OP_W];
    assign w_alu    = alu_f(w_sel_op, w_sel_a, w_sel_b);

    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign rsp_carry = r_rsp_carry;

    // Next-state logic: fill on accept, drain to IDLE when consumed without refill.
    always_comb begin
        // NOTE: default assigned first so every path drives w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = w_accept ? RESP : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, round-robin pointer and result register; result captured only on accept.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_rsp_id    <= '0;
            r_rsp_y     <= '0;
            r_rsp_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr       <= w_idx;
                r_rsp_id    <= w_idx;
                r_rsp_y     <= w_alu[W-1:0];
                r_rsp_carry <= w_alu[W];
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] r_op_cnt [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        // Count accepts of requester g, saturating at 255.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_op_cnt[g] <= '0;
            end else if (w_accept && w_grant[g] && r_op_cnt[g] != 8'hFF) begin
                r_op_cnt[g] <= r_op_cnt[g] + 8'd1;
            end
        end
        assign op_cnt[g*8 +: 8] = r_op_cnt[g];
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb (NREQ=2, W=4). Build with
// ALU_ARB_STATS_EN defined to also exercise the accept counters.
module tb_alu_share_arb;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [5:0] req_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [0:0] rsp_id;
    logic [3:0] rsp_y;
    logic       rsp_carry;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arb #(
        .NREQ (2),
        .W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_carry (rsp_carry)
`ifdef ALU_ARB_STATS_EN
        ,
        .op_cnt    (op_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        req_a[i*4 +: 4]  = a;
        req_b[i*4 +: 4]  = b;
        req_op[i*3 +: 3] = op;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id,
                             input logic [3:0] y, input logic c);
        check({tag, "_valid"}, rsp_valid, v);
        check({tag, "_id"},    rsp_id,    id);
        check({tag, "_y"},     rsp_y,     y);
        check({tag, "_carry"}, rsp_carry, c);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        #1;
        // Reset state; requests present but reset holds grants off
        check_rsp("reset", 1'b0, 1'b0, 4'h0, 1'b0);
        check("reset_ready", req_ready, 2'b00);

        // Test 1: req0 9+8 -> Y=1, carry=1
        rst       = 1'b0;
        req_valid = 2'b01;
        set_req(0, 4'd9, 4'd8, 3'b000);
        #1;
        check("t1_ready", req_ready, 2'b01);
        tick();
        check_rsp("t1_add", 1'b1, 1'b0, 4'h1, 1'b1);

        // Test 2: req1 subtraction with and without borrow, then unused op
        req_valid = 2'b10;
        set_req(1, 4'd3, 4'd5, 3'b001);
        #1;
        check("t2_ready", req_ready, 2'b10);
        tick();
        check_rsp("t2_sub_borrow", 1'b1, 1'b1, 4'hE, 1'b1);
        set_req(1, 4'd5, 4'd3, 3'b001);
        tick();
        check_rsp("t2_sub", 1'b1, 1'b1, 4'h2, 1'b0);
        set_req(1, 4'd7, 4'd7, 3'b101);
        tick();
        check_rsp("t2_op101", 1'b1, 1'b1, 4'h0, 1'b0);
        set_req(1, 4'hC, 4'hA, 3'b011);
        tick();
        check_rsp("t2_or", 1'b1, 1'b1, 4'hE, 1'b0);
        req_valid = 2'b00;
        tick();
        check("t2_drain_valid", rsp_valid, 1'b0);
        tick();
        check("idle_rspready_valid", rsp_valid, 1'b0);
        check("idle_ready", req_ready, 2'b00);

        // Test 3: both valid from reset -> grants 0,1,0,1
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 2'b11;
        set_req(0, 4'd1, 4'd1, 3'b000);   // 1+1 = 2
        set_req(1, 4'd6, 4'd3, 3'b100);   // 6^3 = 5
        #1;
        check("t3_ready0", req_ready, 2'b01);
        tick();
        check_rsp("t3_g0", 1'b1, 1'b0, 4'h2, 1'b0);
        check("t3_ready1", req_ready, 2'b10);
        tick();
        check_rsp("t3_g1", 1'b1, 1'b1, 4'h5, 1'b0);
        check("t3_ready2", req_ready, 2'b01);
        tick();
        check_rsp("t3_g2", 1'b1, 1'b0, 4'h2, 1'b0);
        check("t3_ready3", req_ready, 2'b10);
        tick();
        check_rsp("t3_g3", 1'b1, 1'b1, 4'h5, 1'b0);

        // Test 4: backpressure holds result and blocks grants; operands not resampled
        rsp_ready = 1'b0;
        set_req(1, 4'hF, 4'hF, 3'b000);
        #1;
        check("t4_ready_hold", req_ready, 2'b00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_rsp("t4_hold", 1'b1, 1'b1, 4'h5, 1'b0);
            check("t4_ready", req_ready, 2'b00);
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_release_ready", req_ready, 2'b01);
        tick();
        check_rsp("t4_next", 1'b1, 1'b0, 4'h2, 1'b0);

        // Test 5: reset while in RESP discards result and rewinds pointer
        rst = 1'b1;
        #1;
        check("t5_ready_in_rst", req_ready, 2'b00);
        tick();
        check_rsp("t5_after_rst", 1'b0, 1'b0, 4'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("t5_ready_first", req_ready, 2'b01);
        tick();
        check_rsp("t5_first", 1'b1, 1'b0, 4'h2, 1'b0);
        req_valid = 2'b00;
        tick();
        check("t5_drain", rsp_valid, 1'b0);

`ifdef ALU_ARB_STATS_EN
        // Test 6: counter saturation on req0, req1 untouched
        rst = 1'b1;
        tick();
        check("t6_cnt_clear", op_cnt, 16'h0000);
        rst       = 1'b0;
        req_valid = 2'b01;
        for (int k = 0; k < 300; k++) tick();
        check("t6_cnt0", op_cnt[7:0], 8'd255);
        check("t6_cnt1", op_cnt[15:8], 8'd0);
        req_valid = 2'b00;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
